// File: rtl/cv32e40p_tb_exit_monitor.sv
// Testbench exit monitor for cv32e40p simulations.
// Harts write their exit codes through a zero-wait data port. Once every hart
// has reported, or the watchdog expires, the block latches a pass/fail verdict
// and a final exit value, then stays in DONE until reset.
module cv32e40p_tb_exit_monitor #(
  parameter int unsigned NUM_HARTS      = 1,              // 1..8
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000,  // 0 disables the watchdog
  parameter int unsigned ADDR_WIDTH     = 8               // must reach offset 0x44
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o,
  output logic                  tests_passed_o,
  output logic                  tests_failed_o,
  output logic                  exit_valid_o,
  output logic [31:0]           exit_value_o
);

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(32'h40);
  localparam logic [ADDR_WIDTH-1:0] CYCLES_ADDR = ADDR_WIDTH'(32'h44);

  state_e               state_q;
  logic [31:0]          exit_q [NUM_HARTS];
  logic [NUM_HARTS-1:0] done_q;
  logic                 any_fail_q;
  logic                 timeout_q;
  logic [31:0]          cycles_q;
  logic                 rvalid_q;
  logic [31:0]          rdata_q;
  logic                 passed_q;
  logic                 failed_q;
  logic                 exit_valid_q;
  logic [31:0]          exit_value_q;

  logic [NUM_HARTS-1:0] exit_hit;
  logic [NUM_HARTS-1:0] exit_new;
  logic [NUM_HARTS-1:0] done_d;
  logic                 status_hit;
  logic                 cycles_hit;
  logic                 new_fail;
  logic                 timeout_hit;
  logic [31:0]          wmask;
  logic [31:0]          wdata_masked;
  logic [31:0]          rdata_d;
  logic [31:0]          first_nonzero;
  logic [7:0]           done_ext;

  // Zero-wait slave: every request is granted in the same cycle.
  assign data_gnt_o = data_req_i;

  assign wmask        = {{8{data_be_i[3]}}, {8{data_be_i[2]}},
                         {8{data_be_i[1]}}, {8{data_be_i[0]}}};
  assign wdata_masked = data_wdata_i & wmask;
  assign done_ext     = 8'(done_q);
  assign status_hit   = (data_addr_i == STATUS_ADDR);
  assign cycles_hit   = (data_addr_i == CYCLES_ADDR);

  // Address decode and first-write detection per hart.
  // NOTE: every output of this block is assigned a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    exit_hit = '0;
    exit_new = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      exit_hit[h] = (data_addr_i == ADDR_WIDTH'(4 * h));
      exit_new[h] = exit_hit[h] && data_req_i && data_we_i &&
                    (state_q == RUN) && !done_q[h];
    end
    done_d   = done_q | exit_new;
    new_fail = (|exit_new) && (wdata_masked != 32'h0);
  end

  // Read mux; writes and unmapped offsets return zero.
  always_comb begin
    rdata_d = 32'h0;
    if (data_req_i && !data_we_i) begin
      if (status_hit) begin
        rdata_d = {22'b0, timeout_q, any_fail_q, done_ext};
      end else if (cycles_hit) begin
        rdata_d = cycles_q;
      end else begin
        for (int h = 0; h < NUM_HARTS; h++) begin
          if (exit_hit[h]) rdata_d = exit_q[h];
        end
      end
    end
  end

  // Exit code of the lowest-index hart that reported a nonzero value.
  always_comb begin
    first_nonzero = 32'h0;
    for (int h = NUM_HARTS - 1; h >= 0; h--) begin
      if (exit_q[h] != 32'h0) first_nonzero = exit_q[h];
    end
  end

  // Watchdog fires on the last allowed cycle unless this cycle's write
  // completes the set of harts; completion takes priority.
  assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) &&
                       (cycles_q == TIMEOUT_CYCLES - 32'd1) &&
                       !(&done_d);

  // Control FSM, register file, cycle counter and response path.
  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= RUN;
      // NOTE: the exit registers are software-visible and feed the verdict,
      // so this small array is reset explicitly rather than left undefined.
      for (int h = 0; h < NUM_HARTS; h++) exit_q[h] <= 32'h0;
      done_q       <= '0;
      any_fail_q   <= 1'b0;
      timeout_q    <= 1'b0;
      cycles_q     <= 32'h0;
      rvalid_q     <= 1'b0;
      rdata_q      <= 32'h0;
      passed_q     <= 1'b0;
      failed_q     <= 1'b0;
      exit_valid_q <= 1'b0;
      exit_value_q <= 32'h0;
    end else begin
      rvalid_q     <= data_req_i;
      rdata_q      <= rdata_d;
      exit_valid_q <= 1'b0;
      if (state_q == RUN) begin
        if (cycles_q != 32'hFFFF_FFFF) cycles_q <= cycles_q + 32'd1;
        for (int h = 0; h < NUM_HARTS; h++) begin
          if (exit_new[h]) exit_q[h] <= wdata_masked;
        end
        done_q <= done_d;
        if (new_fail) any_fail_q <= 1'b1;

        if (&done_q) begin
          state_q      <= DONE;
          exit_valid_q <= 1'b1;
          passed_q     <= !any_fail_q;
          failed_q     <= any_fail_q;
          exit_value_q <= first_nonzero;
        end else if (timeout_hit) begin
          state_q      <= DONE;
          exit_valid_q <= 1'b1;
          timeout_q    <= 1'b1;
          failed_q     <= 1'b1;
          exit_value_q <= 32'hFFFF_FFFF;
        end
      end
    end
  end

  assign data_rvalid_o  = rvalid_q;
  assign data_rdata_o   = rdata_q;
  assign tests_passed_o = passed_q;
  assign tests_failed_o = failed_q;
  assign exit_valid_o   = exit_valid_q;
  assign exit_value_o   = exit_value_q;

endmodule

// File: tb/tb_cv32e40p_tb_exit_monitor.sv
// Self-checking bench for cv32e40p_tb_exit_monitor (4 harts, 100-cycle watchdog).
// A behavioural model tracks which harts have reported, their codes and the
// elapsed cycles; a monitor compares every output each cycle, and directed
// scenarios pin the model with hand-computed values.
module tb_cv32e40p_tb_exit_monitor;

  localparam int          NH = 4;
  localparam logic [31:0] TO = 32'd100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [7:0]  addr = 8'h0;
  logic [3:0]  be = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic        gnt, rvalid, passed, failed, exit_valid;
  logic [31:0] rdata, exit_value;

  int tests_run = 0;
  int tests_failed = 0;
  bit mon_en = 1'b0;
  int cyc = 0;

  // Model state
  logic [31:0] m_exit [NH];
  logic [NH-1:0] m_written = '0;
  logic [31:0] m_cyc = 32'h0;
  bit          m_fin = 1'b0;
  bit          m_to = 1'b0;
  logic        exp_rvalid = 1'b0;
  logic [31:0] exp_rdata = 32'h0;
  logic        exp_passed = 1'b0;
  logic        exp_failed = 1'b0;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_value = 32'h0;

  cv32e40p_tb_exit_monitor #(
    .NUM_HARTS(NH),
    .TIMEOUT_CYCLES(TO),
    .ADDR_WIDTH(8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .data_req_i(req),
    .data_gnt_o(gnt),
    .data_addr_i(addr),
    .data_we_i(we),
    .data_be_i(be),
    .data_wdata_i(wdata),
    .data_rvalid_o(rvalid),
    .data_rdata_o(rdata),
    .tests_passed_o(passed),
    .tests_failed_o(failed),
    .exit_valid_o(exit_valid),
    .exit_value_o(exit_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit any_nonzero();
    bit r;
    r = 1'b0;
    for (int h = 0; h < NH; h++) if (m_exit[h] != 32'h0) r = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] lowest_nonzero();
    for (int h = 0; h < NH; h++) if (m_exit[h] != 32'h0) return m_exit[h];
    return 32'h0;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    if (a == 8'h40) return {22'b0, m_to, any_nonzero(), 4'b0, m_written};
    if (a == 8'h44) return m_cyc;
    if (a[1:0] == 2'b00 && int'(a[7:2]) < NH) return m_exit[int'(a[7:2])];
    return 32'h0;
  endfunction

  task automatic model_edge();
    bit          all_before;
    int          idx;
    logic [31:0] v;
    if (rst) begin
      for (int h = 0; h < NH; h++) m_exit[h] = 32'h0;
      m_written = '0; m_cyc = 32'h0; m_fin = 1'b0; m_to = 1'b0;
      exp_rvalid = 1'b0; exp_rdata = 32'h0; exp_passed = 1'b0;
      exp_failed = 1'b0; exp_valid = 1'b0; exp_value = 32'h0;
      return;
    end
    exp_rvalid = req;
    exp_rdata  = (req && !we) ? model_read(addr) : 32'h0;
    exp_valid  = 1'b0;
    if (!m_fin) begin
      all_before = (m_written == {NH{1'b1}});
      idx = int'(addr[7:2]);
      if (req && we && addr[1:0] == 2'b00 && idx < NH && !m_written[idx]) begin
        v = 32'h0;
        for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = wdata[8*b +: 8];
        m_exit[idx] = v;
        m_written[idx] = 1'b1;
      end
      if (all_before) begin
        m_fin = 1'b1; exp_valid = 1'b1;
        exp_passed = !any_nonzero(); exp_failed = any_nonzero();
        exp_value = lowest_nonzero();
      end else if (m_cyc == TO - 1 && m_written != {NH{1'b1}}) begin
        m_fin = 1'b1; m_to = 1'b1; exp_valid = 1'b1;
        exp_failed = 1'b1; exp_value = 32'hFFFF_FFFF;
      end
      if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    #1;
    if (mon_en) begin
      check("gnt", gnt, req);
      check("rvalid", rvalid, exp_rvalid);
      if (exp_rvalid) check("rdata", rdata, exp_rdata);
      check("passed", passed, exp_passed);
      check("failed", failed, exp_failed);
      check("exit_valid", exit_valid, exp_valid);
      check("exit_value", exit_value, exp_value);
      check("pass_fail_excl", passed & failed, 1'b0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset(input int n);
    rst = 1'b1; req = 1'b0; we = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic access(input logic w, input logic [7:0] a, input logic [3:0] b,
                        input logic [31:0] d, output logic [31:0] rd);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    @(negedge clk);
    rd = rdata;
    req = 1'b0; we = 1'b0;
    cyc++;
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) @(negedge clk);
    cyc += n;
  endtask

  task automatic wait_exit(output int n);
    n = 0;
    while (!exit_valid && n < 300) begin
      @(negedge clk);
      n++; cyc++;
    end
    check("exit_seen", exit_valid, 1'b1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    logic [31:0] rd;
    int n;

    do_reset(2);
    mon_en = 1'b1;

    // All harts pass.
    check("rst_valid", exit_valid, 1'b0);
    check("rst_value", exit_value, 32'h0);
    access(1'b0, 8'h40, 4'hF, 32'h0, rd); check("status_init", rd, 32'h0);
    access(1'b0, 8'h44, 4'hF, 32'h0, rd); check("cycles_c1", rd, 32'd1);
    for (int h = 0; h < NH; h++) begin
      access(1'b1, 8'(4 * h), 4'hF, 32'h0, rd);
      check("write_rdata", rd, 32'h0);
    end
    wait_exit(n);
    check("pass_latency", n, 1);
    check("pass_flag", passed, 1'b1);
    check("pass_value", exit_value, 32'h0);

    // Codes 0,0,5,7: fail with the lowest nonzero code.
    do_reset(1);
    access(1'b1, 8'h00, 4'hF, 32'd0, rd);
    access(1'b1, 8'h04, 4'hF, 32'd0, rd);
    access(1'b1, 8'h08, 4'hF, 32'd5, rd);
    idle(3);
    check("no_early_done", failed | passed, 1'b0);
    access(1'b1, 8'h0C, 4'hF, 32'd7, rd);
    wait_exit(n);
    check("fail_latency", n, 1);
    check("fail_flag", failed, 1'b1);
    check("fail_value", exit_value, 32'd5);
    access(1'b0, 8'h40, 4'hF, 32'h0, rd); check("fail_status", rd, 32'h0000_010F);
    access(1'b1, 8'h00, 4'hF, 32'd9, rd);
    access(1'b0, 8'h00, 4'hF, 32'h0, rd); check("done_write_ignored", rd, 32'h0);
    access(1'b0, 8'h08, 4'hF, 32'h0, rd); check("exit2_read", rd, 32'd5);

    // Watchdog expiry with no writes.
    do_reset(1);
    n = 0;
    while (!exit_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycle", n, 100);
    check("timeout_failed", failed, 1'b1);
    check("timeout_value", exit_value, 32'hFFFF_FFFF);
    access(1'b0, 8'h40, 4'hF, 32'h0, rd); check("timeout_status", rd, 32'h0000_0200);
    access(1'b0, 8'h44, 4'hF, 32'h0, rd); check("cycles_frozen", rd, 32'd100);
    check("pulse_once", exit_valid, 1'b0);

    // Final write on the last watchdog cycle: completion wins.
    do_reset(1);
    access(1'b1, 8'h00, 4'hF, 32'd3, rd);
    access(1'b1, 8'h00, 4'hF, 32'd0, rd);
    access(1'b1, 8'h04, 4'hF, 32'd0, rd);
    access(1'b1, 8'h08, 4'hF, 32'd0, rd);
    idle(99 - cyc);
    access(1'b1, 8'h0C, 4'hF, 32'd0, rd);
    wait_exit(n);
    check("race_latency", n, 1);
    check("race_value", exit_value, 32'd3);
    access(1'b0, 8'h40, 4'hF, 32'h0, rd); check("race_status", rd, 32'h0000_010F);
    access(1'b0, 8'h00, 4'hF, 32'h0, rd); check("race_exit0", rd, 32'd3);

    // Byte-enable masking and unmapped read.
    do_reset(1);
    access(1'b1, 8'h00, 4'b0001, 32'h1234_5678, rd);
    access(1'b0, 8'h00, 4'hF, 32'h0, rd); check("partial_write", rd, 32'h0000_0078);
    access(1'b0, 8'h80, 4'hF, 32'h0, rd); check("unmapped_read", rd, 32'h0);
    for (int h = 1; h < NH; h++) access(1'b1, 8'(4 * h), 4'hF, 32'h0, rd);
    wait_exit(n);
    check("partial_value", exit_value, 32'h0000_0078);

    // Reset after DONE with a read in flight, then a clean rerun.
    req = 1'b1; we = 1'b0; addr = 8'h40;
    @(negedge clk);
    do_reset(1);
    check("rst_drop_rvalid", rvalid, 1'b0);
    check("rst_passed", passed, 1'b0);
    check("rst_failed", failed, 1'b0);
    check("rst_exit_value", exit_value, 32'h0);
    access(1'b0, 8'h44, 4'hF, 32'h0, rd); check("cycles_restart", rd, 32'h0);
    for (int h = 0; h < NH; h++) access(1'b1, 8'(4 * h), 4'hF, 32'h0, rd);
    wait_exit(n);
    check("rerun_pass", passed, 1'b1);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cv32e40p_tb_exit_monitor.md
CV32E40P_TB_EXIT_MONITOR -- requirements
Module: cv32e40p_tb_exit_monitor

Interface
REQ-001 Parameter NUM_HARTS, default 1, number of harts reporting exit status; legal range 1..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 32'd1_000_000, watchdog limit in cycles; 0 disables the watchdog.
REQ-003 Parameter ADDR_WIDTH, default 8, number of byte-offset address bits decoded.
REQ-004 Clock and reset: one clock, clk_i; reset is rst_i, synchronous and active-high.
REQ-005 clk_i  in  1  clock; all state updates on rising edge.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 data_req_i  in  1  access request, already address-decoded to this block.
REQ-008 data_gnt_o  out  1  grant.
REQ-009 data_addr_i  in  ADDR_WIDTH  byte offset, word aligned.
REQ-010 data_we_i  in  1  1 = write.
REQ-011 data_be_i  in  4  byte enables.
REQ-012 data_wdata_i  in  32  write data.
REQ-013 data_rvalid_o  out  1  response valid.
REQ-014 data_rdata_o  out  32  read data.
REQ-015 tests_passed_o  out  1  sticky pass flag.
REQ-016 tests_failed_o  out  1  sticky fail flag.
REQ-017 exit_valid_o  out  1  one-cycle pulse on test completion.
REQ-018 exit_value_o  out  32  final exit code; held after the pulse.

Function
REQ-019 Register map: EXIT[h] at 0x00+4*h (h < NUM_HARTS); STATUS at 0x40 = {22'b0, timeout, any_fail, done[7:0]} (done bits above NUM_HARTS-1 read 0); CYCLES at 0x44 = cycle counter.
REQ-020 data_gnt_o shall equal data_req_i combinationally (zero-wait grant).
REQ-021 For every granted access, data_rvalid_o shall assert exactly one cycle later for one cycle; back-to-back accesses give back-to-back rvalid.
REQ-022 Read rdata: the addressed register value, sampled at grant; unmapped offsets and all writes return 32'h0.
REQ-023 EXIT[h] write, first per hart only: store wdata with disabled bytes (be=0) forced to 0; set done[h]; set any_fail if stored value != 0.
REQ-024 Later writes to an already-done EXIT[h], writes to STATUS, CYCLES or unmapped offsets, and all writes in DONE shall be ignored, with normal gnt/rvalid.
REQ-025 FSM states RUN (after reset) and DONE; DONE is left only by rst_i.
REQ-026 In RUN the 32-bit cycle counter increments every cycle, saturating at 32'hFFFF_FFFF; it freezes in DONE.
REQ-027 RUN->DONE (completion): in the cycle after the write that makes done all ones for harts 0..NUM_HARTS-1.
REQ-028 On completion: passed if any_fail=0, else failed; exit_value_o = EXIT of the lowest-index hart with a nonzero value, else 0.
REQ-029 RUN->DONE (timeout): TIMEOUT_CYCLES != 0, counter == TIMEOUT_CYCLES-1 and done not complete; set timeout, failed=1, exit_value_o=32'hFFFF_FFFF.
REQ-030 If the final EXIT write and the timeout condition coincide, completion shall win (timeout=0, evaluation per REQ-028).
REQ-031 exit_valid_o pulses high for exactly one cycle, the first cycle in DONE; tests_passed_o/tests_failed_o assert in the same cycle and stay set; they are never both 1.

Reset
REQ-032 While rst_i=1: FSM=RUN; all EXIT=0; done, any_fail, timeout and counter=0; data_rvalid_o, data_rdata_o, tests_passed_o, tests_failed_o, exit_valid_o=0; exit_value_o=0.
REQ-033 Reset asserted mid-operation, including with a response pending, shall drop the pending rvalid and restart in RUN from the next cycle.

Verification
REQ-034 NUM_HARTS=1: write EXIT[0]=0, be=4'hF -> rvalid next cycle, rdata=0; one cycle later exit_valid_o pulses, tests_passed_o=1, exit_value_o=0.
REQ-035 NUM_HARTS=4: harts write 0,0,5,7 in order -> no DONE until the 4th write; then tests_failed_o=1, exit_value_o=5, STATUS reads 32'h0000_01_0F layout (any_fail=1, done=4'hF).
REQ-036 TIMEOUT_CYCLES=100, no writes -> exit_valid_o pulses at cycle 100 after reset release, tests_failed_o=1, exit_value_o=32'hFFFF_FFFF, STATUS.timeout=1.
REQ-037 NUM_HARTS=2: write EXIT[0]=3 twice with the second value 0, then EXIT[1]=0 on cycle TIMEOUT_CYCLES-1 -> second EXIT[0] write ignored, completion wins, exit_value_o=3, timeout=0.
REQ-038 Partial write EXIT[0]=32'h1234_5678 with be=4'b0001 -> stored 32'h0000_0078, read back 32'h78; unmapped read at 0x80 -> rdata=0.
REQ-039 Assert rst_i for 1 cycle after DONE -> all flags 0, counter restarts at 0, new test completes normally.
